// File: rtl/archer_div_unit_pkg.sv
// rtl/archer_div_unit_pkg.sv - shared divider definitions (archerdefs) and FSM/op encodings
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DIV_OP_DIV
`define DIV_OP_DIV  2'b00
`define DIV_OP_DIVU 2'b01
`define DIV_OP_REM  2'b10
`define DIV_OP_REMU 2'b11
`endif
`ifndef DIV_S_IDLE
`define DIV_S_IDLE 2'd0
`define DIV_S_CALC 2'd1
`define DIV_S_DONE 2'd2
`endif

package archer_div_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = `DIV_S_IDLE,
        S_CALC = `DIV_S_CALC,
        S_DONE = `DIV_S_DONE
    } div_state_e;

    localparam logic [1:0] OP_DIV  = `DIV_OP_DIV;
    localparam logic [1:0] OP_DIVU = `DIV_OP_DIVU;
    localparam logic [1:0] OP_REM  = `DIV_OP_REM;
    localparam logic [1:0] OP_REMU = `DIV_OP_REMU;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/archer_div_core.sv
// rtl/archer_div_core.sv - unsigned restoring shift-subtract datapath, one quotient bit per step
module archer_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_next_o,
    output logic [XLEN-1:0] rem_next_o
);

    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic            ge;

    // shifted is the XLEN+1-bit accumulator; the spare MSB keeps the compare exact
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_d   = shifted[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], 1'b0};
        if (ge) begin
            rem_d = XLEN'(shifted - {1'b0, dvs_q});
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quo_next_o = quo_d;
    assign rem_next_o = rem_d;

endmodule

// File: rtl/archer_div_unit.sv
// rtl/archer_div_unit.sv - RV32M DIV/DIVU/REM/REMU iterative divider; ARCHER_DIV_BYPASS_EN shortcuts special cases
`ifndef XLEN
`define XLEN 32
`endif
module archer_div_unit
    import archer_div_unit_pkg::*;
#(
    parameter int XLEN = `XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] orig_q;
    logic            op_rem_q, neg_quo_q, neg_rem_q, divz_q, ovf_q;

    logic            accept, is_signed, sgn_a, sgn_b, divz_d, ovf_d, bypass_d;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] quo_nx, rem_nx, quo_fin, rem_fin, result_d;

    always_comb begin
        accept    = start && (state_q != S_CALC);
        is_signed = op_is_signed(op);
        sgn_a     = is_signed & dividend[XLEN-1];
        sgn_b     = is_signed & divisor[XLEN-1];
        mag_a     = sgn_a ? -dividend : dividend;
        mag_b     = sgn_b ? -divisor  : divisor;
        divz_d    = (divisor == '0);
        ovf_d     = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    end

`ifdef ARCHER_DIV_BYPASS_EN
    assign bypass_d = divz_d | ovf_d;
`else
    assign bypass_d = 1'b0;
`endif

    archer_div_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .step_i     (state_q == S_CALC),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quo_next_o (quo_nx),
        .rem_next_o (rem_nx)
    );

    // Special cases override the datapath so both builds return identical results
    always_comb begin
        quo_fin = neg_quo_q ? -quo_nx : quo_nx;
        rem_fin = neg_rem_q ? -rem_nx : rem_nx;
        if (divz_q) begin
            quo_fin = '1;
            rem_fin = orig_q;
        end else if (ovf_q) begin
            quo_fin = MIN_NEG;
            rem_fin = '0;
        end
        result_d = op_rem_q ? rem_fin : quo_fin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            orig_q    <= '0;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        state_q   <= S_CALC;
                        busy_q    <= 1'b1;
                        // bypassed ops spend a single busy cycle before DONE
                        cnt_q     <= bypass_d ? '0 : CW'(XLEN - 1);
                        orig_q    <= dividend;
                        op_rem_q  <= op[1];
                        neg_quo_q <= sgn_a ^ sgn_b;
                        neg_rem_q <= sgn_a;
                        divz_q    <= divz_d;
                        ovf_q     <= ovf_d;
                    end
                end
                S_CALC: begin
                    if (cnt_q == '0) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= result_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_archer_div_unit.sv
// tb/tb_archer_div_unit.sv - scoreboard bench for archer_div_unit (default build latency)
module tb_archer_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    archer_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (o[0] == 1'b0);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        if (sgn) return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return o[1] ? a % b : a / b;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            check("busy_at_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_result"}, result, mon_e.res);
                check({mon_e.tag, "_done_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    // Caller is at a negedge; returns k = cycle counter seen during cycle 1
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input string tag, output int k);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        k = cyc;
        sb.push_back('{tag, want, k + 32});
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_drain"}, sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int k;
        int k2;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'd100, 32'd7, 32'd14, "div_100_7", k);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            check($sformatf("busy_cycle_%0d", i), {31'd0, busy}, {31'd0, (i <= 32)});
        end
        wait_drain("div_100_7");

        vecs.push_back('{2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, "rem_m100_7"});
        vecs.push_back('{2'b01, 32'hFFFF_FF9C, 32'd7,         32'h2492_4916, "divu_big_7"});
        vecs.push_back('{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0"});
        vecs.push_back('{2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_m5_0"});
        vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_m5_0"});
        vecs.push_back('{2'b11, 32'd5,         32'd0,         32'd5,         "remu_5_0"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf"});
        vecs.push_back('{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"});
        vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         "rem_7_m2"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'd1,         32'h8000_0000, "div_min_1"});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, "remu_max_min"});
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].want, vecs[i].tag, k);
            wait_drain(vecs[i].tag);
        end

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 4 == 1) rb = -rb;
            issue(ro, ra, rb, model(ro, ra, rb), $sformatf("rand_%0d", i), k);
            wait_drain($sformatf("rand_%0d", i));
        end

        issue(2'b01, 32'd1000, 32'd10, 32'd100, "divu_1000_10", k);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b10; dividend = 32'd7; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 32) @(negedge clk);
        issue(2'b00, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6, "b2b_div_50_m5", k2);
        check("b2b_accept_cycle", k2, k + 33);
        wait_drain("b2b");

        issue(2'b00, 32'd1234, 32'd5, 32'd246, "reset_victim", k);
        while (cyc < k + 14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   {31'd0, busy}, 32'd0);
        check("async_rst_done",   {31'd0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        issue(2'b00, 32'd9, 32'd3, 32'd3, "div_9_3", k);
        wait_drain("div_9_3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
